demux12_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer, the receive-side counterpart of the 2:1 mux datapath.
- Takes one valid/ready input stream carrying a select bit and steers each beat to output port 0 or output port 1.
- Each output has a 2-entry FIFO, so a stalled output never blocks beats bound for the other output.
- Sits between a shared source and two independent consumers.

---
 rtl/demux12_stream.sv | 152 +++++++++++++++
 tb/tb_demux12_stream.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/demux12_stream.sv
// demux12_stream -- registered 1-to-2 valid/ready stream demultiplexer.
//
// Each input beat carries a select bit. The beat is steered into one of two
// 2-entry FIFOs, and each FIFO feeds its own output port. A stalled consumer
// therefore only back-pressures beats that are bound for its own port.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_data/in_sel    input beat payload and destination (0 = out0, 1 = out1)
//   in_valid/in_ready input handshake; in_ready = !full(FIFO[in_sel])
//   outN_data         head of FIFO N (0 while FIFO N is empty)
//   outN_valid        FIFO N is non-empty
//   outN_ready        consumer N takes the head
//   cnt0, cnt1        16-bit pop counters (only with DEMUX12_STATS_EN defined)
//
// Optional feature macro: DEMUX12_STATS_EN

// Two-entry FIFO with 1-bit pointers and a 0..2 occupancy count.
module demux12_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic         full_o
);
    logic [1:0][W-1:0] mem_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q, cnt_d;

    // Push and pop together leave the count alone; callers never push when
    // full or pop when empty, so no saturation is needed here.
    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i)
                rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    // Stale storage is masked so an empty port always shows zero.
    assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
endmodule

module demux12_stream #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_sel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out0_data,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [W-1:0] out1_data,
    output logic         out1_valid,
    input  logic         out1_ready
`ifdef DEMUX12_STATS_EN
    ,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
`endif
);
    localparam int NUM_PORTS = 2;

    logic [NUM_PORTS-1:0][W-1:0] dout;
    logic [NUM_PORTS-1:0]        valid;
    logic [NUM_PORTS-1:0]        full;
    logic [NUM_PORTS-1:0]        push;
    logic [NUM_PORTS-1:0]        pop;
    logic [NUM_PORTS-1:0]        out_rdy;

    assign out_rdy = {out1_ready, out0_ready};

    // Ready looks only at the selected FIFO's fullness, never at in_valid.
    // A full FIFO popping this cycle still reports not-ready (no bypass).
    assign in_ready = ~rst & ~full[in_sel];

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
            assign push[g] = in_valid & in_ready & (in_sel == 1'(g));
            assign pop[g]  = valid[g] & out_rdy[g];

            demux12_fifo2 #(.W(W)) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .push_i  (push[g]),
                .din_i   (in_data),
                .pop_i   (pop[g]),
                .dout_o  (dout[g]),
                .valid_o (valid[g]),
                .full_o  (full[g])
            );
        end
    endgenerate

    assign out0_data  = dout[0];
    assign out0_valid = valid[0];
    assign out1_data  = dout[1];
    assign out1_valid = valid[1];

`ifdef DEMUX12_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // 16-bit counters wrap naturally from 0xFFFF to 0x0000.
    always_comb begin
        cnt0_d = cnt0_q + 16'(pop[0]);
        cnt1_d = cnt1_q + 16'(pop[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_demux12_stream.sv
// Directed bench for demux12_stream: a vector table of per-cycle inputs and
// expected outputs, plus hand-written sequences for alternating backpressure
// and (when DEMUX12_STATS_EN is defined) pop-counter wrap.
module tb_demux12_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
`ifdef DEMUX12_STATS_EN
    logic [15:0] cnt0, cnt1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux12_stream #(.W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX12_STATS_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    typedef struct {
        logic       rst, vld, sel, r0, r1;
        logic [7:0] data;
        logic       e_ir, e_v0;
        logic [7:0] e_d0;
        logic       e_v1;
        logic [7:0] e_d1;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rs, logic v, logic [7:0] d, logic s,
                                logic r0, logic r1, logic ir, logic v0,
                                logic [7:0] d0, logic v1, logic [7:0] d1);
        vec_t t;
        t.rst = rs; t.vld = v; t.data = d; t.sel = s; t.r0 = r0; t.r1 = r1;
        t.e_ir = ir; t.e_v0 = v0; t.e_d0 = d0; t.e_v1 = v1; t.e_d1 = d1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Rows: rst vld data sel r0 r1 | in_ready v0 d0 v1 d1 (outputs seen
        // before the edge that consumes the row's inputs).
        // Reset held with in_valid high, then release.
        vq.push_back(mk(1,1,8'hFF,0,1,1, 0, 0,8'h00, 0,8'h00));
        vq.push_back(mk(0,0,8'h00,0,1,1, 1, 0,8'h00, 0,8'h00));
        // Steering 0x11->0, 0x22->1, 0x33->0 with both readies high.
        vq.push_back(mk(0,1,8'h11,0,1,1, 1, 0,8'h00, 0,8'h00));
        vq.push_back(mk(0,1,8'h22,1,1,1, 1, 1,8'h11, 0,8'h00));
        vq.push_back(mk(0,1,8'h33,0,1,1, 1, 0,8'h00, 1,8'h22));
        vq.push_back(mk(0,0,8'hEE,1,1,1, 1, 1,8'h33, 0,8'h00));
        vq.push_back(mk(0,0,8'hEE,0,1,1, 1, 0,8'h00, 0,8'h00));
        // Fill FIFO0 with out0 stalled; 0xA3 refused.
        vq.push_back(mk(0,1,8'hA1,0,0,1, 1, 0,8'h00, 0,8'h00));
        vq.push_back(mk(0,1,8'hA2,0,0,1, 1, 1,8'hA1, 0,8'h00));
        vq.push_back(mk(0,1,8'hA3,0,0,1, 0, 1,8'hA1, 0,8'h00));
        // Independence: out1 still accepts while out0 is full and stalled.
        vq.push_back(mk(0,1,8'h5C,1,0,1, 1, 1,8'hA1, 0,8'h00));
        // Pop from full FIFO0: no bypass, 0xA3 still refused this cycle.
        vq.push_back(mk(0,1,8'hA3,0,1,1, 0, 1,8'hA1, 1,8'h5C));
        // 0xA3 accepted one cycle after the first pop (push+pop at count 1).
        vq.push_back(mk(0,1,8'hA3,0,1,1, 1, 1,8'hA2, 0,8'h00));
        vq.push_back(mk(0,0,8'h00,0,1,1, 1, 1,8'hA3, 0,8'h00));
        vq.push_back(mk(0,0,8'h00,0,1,1, 1, 0,8'h00, 0,8'h00));
        // Reset mid-stream with 0x01, 0x02 buffered.
        vq.push_back(mk(0,1,8'h01,0,0,1, 1, 0,8'h00, 0,8'h00));
        vq.push_back(mk(0,1,8'h02,0,0,1, 1, 1,8'h01, 0,8'h00));
        vq.push_back(mk(1,0,8'h00,0,0,1, 0, 1,8'h01, 0,8'h00));
        vq.push_back(mk(0,0,8'h00,0,1,1, 1, 0,8'h00, 0,8'h00));
        vq.push_back(mk(0,0,8'h00,0,1,1, 1, 0,8'h00, 0,8'h00));
        // FIFO1 fills while FIFO0 pushes and pops independently.
        vq.push_back(mk(0,1,8'hB1,1,1,0, 1, 0,8'h00, 0,8'h00));
        vq.push_back(mk(0,1,8'hB2,1,1,0, 1, 0,8'h00, 1,8'hB1));
        vq.push_back(mk(0,1,8'hC1,0,1,0, 1, 0,8'h00, 1,8'hB1));
        vq.push_back(mk(0,1,8'hB3,1,1,0, 0, 1,8'hC1, 1,8'hB1));
        vq.push_back(mk(0,0,8'h00,1,1,1, 0, 0,8'h00, 1,8'hB1));
        vq.push_back(mk(0,0,8'h00,1,1,1, 1, 0,8'h00, 1,8'hB2));
        vq.push_back(mk(0,0,8'h00,1,1,1, 1, 0,8'h00, 0,8'h00));

        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; in_sel = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        step();

        foreach (vq[i]) begin
            rst = vq[i].rst; in_valid = vq[i].vld; in_data = vq[i].data;
            in_sel = vq[i].sel; out0_ready = vq[i].r0; out1_ready = vq[i].r1;
            #1;
            chk($sformatf("row%0d in_ready", i),   16'(in_ready),   16'(vq[i].e_ir));
            chk($sformatf("row%0d out0_valid", i), 16'(out0_valid), 16'(vq[i].e_v0));
            chk($sformatf("row%0d out0_data", i),  16'(out0_data),  16'(vq[i].e_d0));
            chk($sformatf("row%0d out1_valid", i), 16'(out1_valid), 16'(vq[i].e_v1));
            chk($sformatf("row%0d out1_data", i),  16'(out1_data),  16'(vq[i].e_d1));
            step();
        end

        // Alternating out0 backpressure: 8 beats must emerge in order.
        begin
            logic [7:0] exp_q[$];
            int sent = 0, got = 0;
            rst = 1'b0; in_sel = 1'b0; out1_ready = 1'b1;
            for (int c = 0; c < 60 && got < 8; c++) begin
                logic acc;
                in_valid   = (sent < 8);
                in_data    = 8'h40 + 8'(sent);
                out0_ready = c[0];
                #1;
                chk($sformatf("alt c%0d out0_valid", c), 16'(out0_valid),
                    16'(exp_q.size() != 0));
                if (out0_valid && out0_ready && exp_q.size() != 0) begin
                    chk($sformatf("alt beat%0d", got), 16'(out0_data),
                        16'(exp_q.pop_front()));
                    got++;
                end
                acc = in_valid & in_ready;
                step();
                if (acc) begin
                    exp_q.push_back(8'h40 + 8'(sent));
                    sent++;
                end
            end
            chk("alt beats received", 16'(got), 16'd8);
            in_valid = 1'b0;
        end

`ifdef DEMUX12_STATS_EN
        // 70000 pops on out1 wrap cnt1 to 4464; cnt0 stays clear.
        rst = 1'b1; step();
        rst = 1'b0;
        chk("stats cnt1 after rst", cnt1, 16'd0);
        in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h77;
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int k = 0; k < 70000; k++) step();
        in_valid = 1'b0;
        step(); step();
        chk("stats cnt1 wrap", cnt1, 16'd4464);
        chk("stats cnt0", cnt0, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
